quick_spi_slave: RTL and testbench
==================================

QUICK_SPI_SLAVE -- requirements
Module: quick_spi_slave

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DATA_WIDTH, 16, frame length in bits, legal range 1..64.
- CPOL, 0, SCLK idle level.
- CPHA, 0, SPI clock phase: 0 = sample on leading edge, 1 = sample on trailing edge.
- BITS_ORDER, 1, bit order on the wire: 1 = MSB first, 0 = LSB first.
- MISO_IDLE_VALUE, 1'b0, MISO level whenever no frame is in progress.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, input, 1, system clock; the only clock in the block.
- reset, input, 1, synchronous, active-high reset.
- enable, input, 1, allows a new frame to start.
- sclk, input, 1, SPI clock from the master; asynchronous to clk.
- ss_n, input, 1, active-low slave select; asynchronous to clk.
- mosi, input, 1, master-to-slave data; asynchronous to clk.
- miso, output, 1, slave-to-master data.
- miso_oe, output, 1, MISO pad driver enable.
- tx_data, input, DATA_WIDTH, word to transmit; captured at frame start.
- rx_data, output, DATA_WIDTH, last complete received word.
- rx_valid, output, 1, one-cycle pulse when rx_data is updated.
- frame_error, output, 1, one-cycle pulse when a frame ends with the wrong bit count.
- busy, output, 1, high while a frame is in progress.

Function
REQ-003 sclk, ss_n and mosi SHALL each pass through a 2-flop synchronizer; all edge detection SHALL use the synchronized values.
REQ-004 Leading edge SHALL mean synchronized sclk moving away from CPOL; trailing edge SHALL mean synchronized sclk returning to CPOL.
REQ-005 The sample edge SHALL be the leading edge when CPHA=0 and the trailing edge when CPHA=1; the shift edge SHALL be the other edge.
REQ-006 The state machine SHALL have three states: IDLE, ACTIVE and DONE.
REQ-007 IDLE -> ACTIVE SHALL occur on the synchronized ss_n falling edge while enable=1. On this transition the block SHALL:
- capture tx_data into the shift register;
- clear the bit counter;
- set busy=1 and miso_oe=1.
REQ-008 In IDLE, an ss_n falling edge with enable=0 SHALL be ignored for the whole frame; miso_oe stays 0.
REQ-009 When CPHA=0, miso SHALL present the first bit in the cycle after the IDLE->ACTIVE transition. When CPHA=1, miso SHALL present the first bit on the first leading edge.
REQ-010 Each subsequent shift edge SHALL advance miso to the next bit in BITS_ORDER order.
REQ-011 Once DATA_WIDTH bits have been shifted out, miso SHALL hold MISO_IDLE_VALUE.
REQ-012 On each sample edge the block SHALL shift synchronized mosi into the receive register in BITS_ORDER order. The bit counter SHALL increment and saturate at DATA_WIDTH+1; bits after the DATA_WIDTH-th SHALL be discarded.
REQ-013 ACTIVE -> DONE SHALL occur on the synchronized ss_n rising edge.
REQ-014 In DONE, for exactly one cycle:
- if the bit count equals DATA_WIDTH: rx_data <= receive register and rx_valid=1;
- if the bit count is between 1 and DATA_WIDTH-1, or equals DATA_WIDTH+1: frame_error=1 and rx_data is unchanged;
- if the bit count is 0: neither rx_valid nor frame_error pulses.
REQ-015 DONE -> IDLE SHALL occur unconditionally after one cycle. In this transition busy=0, miso_oe=0 and miso=MISO_IDLE_VALUE.
REQ-016 rx_valid and frame_error SHALL never be high in the same cycle, and each SHALL be high for exactly one clk cycle.
REQ-017 enable SHALL be examined only in IDLE; deasserting it mid-frame SHALL NOT abort the frame.
REQ-018 Correct operation SHALL be guaranteed when every sclk high and low phase lasts at least 4 clk periods and ss_n setup/hold to the first/last sclk edge is at least 4 clk periods.
REQ-019 End-to-end latency: rx_valid SHALL rise 4 clk cycles after the raw ss_n rising edge (2 synchronizer flops, 1 edge-detect cycle, 1 DONE cycle).

Reset
REQ-020 While reset=1 at a rising edge of clk, the block SHALL drive:
- state=IDLE, busy=0, miso_oe=0, miso=MISO_IDLE_VALUE;
- rx_data=0, rx_valid=0, frame_error=0;
- bit counter and shift registers = 0;
- synchronizer flops: ss_n=1, sclk=CPOL, mosi=0.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no rx_valid or frame_error pulse. After reset is released, a frame still in progress (ss_n already low) SHALL be ignored until ss_n rises and falls again.

Verification
REQ-022 Mode 0, MSB first, DATA_WIDTH=16, tx_data=16'hA5C3, master sends 16'h1234 -> master reads 16'hA5C3 on miso; rx_data=16'h1234 with a single rx_valid pulse 4 cycles after ss_n rises.
REQ-023 Mode 3 (CPOL=1, CPHA=1), LSB first, DATA_WIDTH=11, master sends 11'h5A1 -> rx_data=11'h5A1; miso bits match tx_data LSB first.
REQ-024 Master sends 9 clocks in a 16-bit frame, then raises ss_n -> frame_error pulses once; rx_data keeps its previous value; busy returns to 0.
REQ-025 Master sends 17 clocks in a 16-bit frame -> frame_error pulses once; miso=MISO_IDLE_VALUE during the 17th bit.
REQ-026 ss_n low/high with no sclk edges -> no rx_valid, no frame_error; busy pulses high then low. With enable=0 and a full 16-bit frame -> miso_oe stays 0 and there is no pulse.
REQ-027 reset asserted after 8 bits, then held 2 cycles -> all outputs return to their reset values; the remainder of that frame produces no output pulse.

Source files
------------

// File: rtl/quick_spi_slave.sv
// SPI slave with a single clk domain: sclk/ss_n/mosi are synchronized and edge-detected,
// then a three-state FSM (IDLE/ACTIVE/DONE) frames one DATA_WIDTH-bit word per ss_n assertion.
module quick_spi_slave #(
    parameter int   DATA_WIDTH      = 16,
    parameter bit   CPOL            = 1'b0,
    parameter bit   CPHA            = 1'b0,
    parameter bit   BITS_ORDER      = 1'b1,
    parameter logic MISO_IDLE_VALUE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] OVER_CNT = CNT_W'(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t                  state_reg, state_next;
    logic                    sclk_meta_reg, sclk_sync_reg, sclk_prev_reg;
    logic                    ss_n_meta_reg, ss_n_sync_reg, ss_n_prev_reg;
    logic                    mosi_meta_reg, mosi_sync_reg;
    logic [1:0]              flush_cnt_reg;
    logic                    armed_reg;
    logic [CNT_W-1:0]        bit_cnt_reg, tx_cnt_reg;
    logic [DATA_WIDTH-1:0]   rx_shift_reg, tx_shift_reg, rx_data_reg;
    logic                    miso_reg, rx_valid_reg, frame_error_reg;

    logic sclk_lead, sclk_trail, sample_edge, shift_edge;
    logic ss_fall, ss_rise, frame_start;

    // Synchronizers plus one stage of history for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_meta_reg <= CPOL;
            sclk_sync_reg <= CPOL;
            sclk_prev_reg <= CPOL;
            ss_n_meta_reg <= 1'b1;
            ss_n_sync_reg <= 1'b1;
            ss_n_prev_reg <= 1'b1;
            mosi_meta_reg <= 1'b0;
            mosi_sync_reg <= 1'b0;
            flush_cnt_reg <= 2'd0;
            armed_reg     <= 1'b0;
        end else begin
            sclk_meta_reg <= sclk;
            sclk_sync_reg <= sclk_meta_reg;
            sclk_prev_reg <= sclk_sync_reg;
            ss_n_meta_reg <= ss_n;
            ss_n_sync_reg <= ss_n_meta_reg;
            ss_n_prev_reg <= ss_n_sync_reg;
            mosi_meta_reg <= mosi;
            mosi_sync_reg <= mosi_meta_reg;
            flush_cnt_reg <= (flush_cnt_reg == 2'd2) ? flush_cnt_reg : flush_cnt_reg + 2'd1;
            // Only arm once a genuinely high ss_n has passed through the flushed synchronizer,
            // so a frame already running when reset drops is ignored until ss_n cycles.
            armed_reg     <= armed_reg | ((flush_cnt_reg == 2'd2) & ss_n_sync_reg);
        end
    end

    assign sclk_lead   = (sclk_sync_reg != CPOL) && (sclk_prev_reg == CPOL);
    assign sclk_trail  = (sclk_sync_reg == CPOL) && (sclk_prev_reg != CPOL);
    assign sample_edge = CPHA ? sclk_trail : sclk_lead;
    assign shift_edge  = CPHA ? sclk_lead : sclk_trail;
    assign ss_fall     = armed_reg & ss_n_prev_reg & ~ss_n_sync_reg;
    assign ss_rise     = ~ss_n_prev_reg & ss_n_sync_reg;
    assign frame_start = (state_reg == IDLE) && ss_fall && enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (frame_start) state_next = ACTIVE;
            ACTIVE:  if (ss_rise) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_reg != IDLE);
        miso_oe = (state_reg != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_reg     <= '0;
            tx_cnt_reg      <= '0;
            rx_shift_reg    <= '0;
            tx_shift_reg    <= '0;
            rx_data_reg     <= '0;
            miso_reg        <= MISO_IDLE_VALUE;
            rx_valid_reg    <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            rx_valid_reg    <= 1'b0;
            frame_error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    miso_reg <= MISO_IDLE_VALUE;
                    if (frame_start) begin
                        bit_cnt_reg  <= '0;
                        rx_shift_reg <= '0;
                        // With CPHA=0 the first bit must already be on the wire before the first edge.
                        if (CPHA == 1'b0) begin
                            miso_reg     <= BITS_ORDER ? tx_data[DATA_WIDTH-1] : tx_data[0];
                            tx_shift_reg <= BITS_ORDER ? (tx_data << 1) : (tx_data >> 1);
                            tx_cnt_reg   <= CNT_W'(1);
                        end else begin
                            tx_shift_reg <= tx_data;
                            tx_cnt_reg   <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    if (sample_edge) begin
                        if (bit_cnt_reg < FULL_CNT) begin
                            rx_shift_reg <= BITS_ORDER
                                ? ((rx_shift_reg << 1) | DATA_WIDTH'(mosi_sync_reg))
                                : ((rx_shift_reg >> 1) | (DATA_WIDTH'(mosi_sync_reg) << (DATA_WIDTH - 1)));
                        end
                        if (bit_cnt_reg != OVER_CNT) begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                    end
                    if (shift_edge) begin
                        if (tx_cnt_reg < FULL_CNT) begin
                            miso_reg     <= BITS_ORDER ? tx_shift_reg[DATA_WIDTH-1] : tx_shift_reg[0];
                            tx_shift_reg <= BITS_ORDER ? (tx_shift_reg << 1) : (tx_shift_reg >> 1);
                            tx_cnt_reg   <= tx_cnt_reg + CNT_W'(1);
                        end else begin
                            miso_reg <= MISO_IDLE_VALUE;
                        end
                    end
                end
                DONE: begin
                    miso_reg <= MISO_IDLE_VALUE;
                    if (bit_cnt_reg == FULL_CNT) begin
                        rx_data_reg  <= rx_shift_reg;
                        rx_valid_reg <= 1'b1;
                    end else if (bit_cnt_reg != '0) begin
                        frame_error_reg <= 1'b1;
                    end
                end
                default: miso_reg <= MISO_IDLE_VALUE;
            endcase
        end
    end

    assign miso        = miso_reg;
    assign rx_data     = rx_data_reg;
    assign rx_valid    = rx_valid_reg;
    assign frame_error = frame_error_reg;

endmodule

// File: tb/tb_quick_spi_slave.sv
// Directed bench: a mode-0/MSB/16-bit slave and a mode-3/LSB/11-bit slave driven by a bit-banged master.
module tb_quick_spi_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        enable0 = 1'b1, sclk0 = 1'b0, ss_n0 = 1'b1, mosi0 = 1'b0;
    logic        miso0, miso_oe0, rx_valid0, frame_error0, busy0;
    logic [15:0] tx_data0 = 16'h0000, rx_data0;

    logic        enable3 = 1'b1, sclk3 = 1'b1, ss_n3 = 1'b1, mosi3 = 1'b0;
    logic        miso3, miso_oe3, rx_valid3, frame_error3, busy3;
    logic [10:0] tx_data3 = 11'h000, rx_data3;

    int n_tests = 0, n_fail = 0;
    int v_cnt = 0, e_cnt = 0, v3_cnt = 0, e3_cnt = 0, both_cnt = 0;
    logic oe_seen = 1'b0, busy_seen = 1'b0;

    always #5 clk = ~clk;

    quick_spi_slave #(.DATA_WIDTH(16), .CPOL(1'b0), .CPHA(1'b0), .BITS_ORDER(1'b1),
                      .MISO_IDLE_VALUE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable0), .sclk(sclk0), .ss_n(ss_n0), .mosi(mosi0),
        .miso(miso0), .miso_oe(miso_oe0), .tx_data(tx_data0), .rx_data(rx_data0),
        .rx_valid(rx_valid0), .frame_error(frame_error0), .busy(busy0));

    quick_spi_slave #(.DATA_WIDTH(11), .CPOL(1'b1), .CPHA(1'b1), .BITS_ORDER(1'b0),
                      .MISO_IDLE_VALUE(1'b0)) dut3 (
        .clk(clk), .reset(reset), .enable(enable3), .sclk(sclk3), .ss_n(ss_n3), .mosi(mosi3),
        .miso(miso3), .miso_oe(miso_oe3), .tx_data(tx_data3), .rx_data(rx_data3),
        .rx_valid(rx_valid3), .frame_error(frame_error3), .busy(busy3));

    always @(negedge clk) begin
        if (rx_valid0) v_cnt++;
        if (frame_error0) e_cnt++;
        if (rx_valid0 && frame_error0) both_cnt++;
        if (miso_oe0) oe_seen = 1'b1;
        if (busy0) busy_seen = 1'b1;
        if (rx_valid3) v3_cnt++;
        if (frame_error3) e3_cnt++;
    end

    task automatic clear_mon();
        #1;
        v_cnt = 0; e_cnt = 0; v3_cnt = 0; e3_cnt = 0;
        oe_seen = 1'b0; busy_seen = 1'b0;
    endtask

    // Mode 0 master bit: data set while sclk low, slave data read just before the rising edge.
    task automatic bit0(input logic b, output logic r);
        mosi0 = b;
        repeat (5) @(negedge clk);
        r = miso0;
        sclk0 = 1'b1;
        repeat (5) @(negedge clk);
        sclk0 = 1'b0;
    endtask

    // Mode 3 master bit: falling (leading) edge launches, rising (trailing) edge samples.
    task automatic bit3(input logic b, output logic r);
        sclk3 = 1'b0;
        mosi3 = b;
        repeat (5) @(negedge clk);
        r = miso3;
        sclk3 = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // Send nbits of mo MSB first (zeros past bit 15), return the miso bits read.
    task automatic frame0(input int nbits, input logic [15:0] mo, output logic [31:0] rd);
        logic r;
        rd = '0;
        ss_n0 = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bit0((i < 16) ? mo[15-i] : 1'b0, r);
            rd[31-i] = r;
        end
        repeat (6) @(negedge clk);
        ss_n0 = 1'b1;
    endtask

    task automatic measure0(output int lat);
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (rx_valid0 && lat < 0) lat = c;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy0); end
        n_tests++; if (miso_oe0 !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b need 0", miso_oe0); end
        n_tests++; if (miso0 !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b need 0", miso0); end
        n_tests++; if (rx_data0 !== 16'h0000) begin n_fail++; $display("FAIL reset_rx: got %h need 0000", rx_data0); end
        n_tests++; if (rx_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b need 0", rx_valid0); end
        n_tests++; if (frame_error0 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b need 0", frame_error0); end
        n_tests++; if (rx_data3 !== 11'h000) begin n_fail++; $display("FAIL reset_rx3: got %h need 000", rx_data3); end
        n_tests++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL reset_busy3: got %b need 0", busy3); end
        $display("[TB] reset: busy=%b oe=%b miso=%b rx=%h", busy0, miso_oe0, miso0, rx_data0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_mode0();
        logic [31:0] rd;
        int lat;
        tx_data0 = 16'hA5C3;
        clear_mon();
        frame0(16, 16'h1234, rd);
        measure0(lat);
        n_tests++; if (rd[31:16] !== 16'hA5C3) begin n_fail++; $display("FAIL mode0_miso: got %h need a5c3", rd[31:16]); end
        n_tests++; if (rx_data0 !== 16'h1234) begin n_fail++; $display("FAIL mode0_rx: got %h need 1234", rx_data0); end
        n_tests++; if (v_cnt !== 1) begin n_fail++; $display("FAIL mode0_valid_count: got %0d need 1", v_cnt); end
        n_tests++; if (e_cnt !== 0) begin n_fail++; $display("FAIL mode0_err_count: got %0d need 0", e_cnt); end
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL mode0_latency: got %0d need 4", lat); end
        n_tests++; if (oe_seen !== 1'b1) begin n_fail++; $display("FAIL mode0_oe_seen: got %b need 1", oe_seen); end
        n_tests++; if (busy0 !== 1'b0 || miso_oe0 !== 1'b0) begin n_fail++; $display("FAIL mode0_end_idle: busy %b oe %b need 0 0", busy0, miso_oe0); end
        $display("[TB] mode0: master read %h, rx_data %h, latency %0d", rd[31:16], rx_data0, lat);
    endtask

    task automatic test_mode3();
        logic [10:0] mo, rd;
        logic r;
        mo = 11'h5A1;
        rd = '0;
        tx_data3 = 11'h3C5;
        clear_mon();
        ss_n3 = 1'b0;
        repeat (6) @(negedge clk);
        tx_data3 = 11'h000;
        for (int i = 0; i < 11; i++) begin
            bit3(mo[i], r);
            rd[i] = r;
        end
        repeat (6) @(negedge clk);
        ss_n3 = 1'b1;
        repeat (12) @(negedge clk);
        n_tests++; if (rd !== 11'h3C5) begin n_fail++; $display("FAIL mode3_miso: got %h need 3c5", rd); end
        n_tests++; if (rx_data3 !== 11'h5A1) begin n_fail++; $display("FAIL mode3_rx: got %h need 5a1", rx_data3); end
        n_tests++; if (v3_cnt !== 1 || e3_cnt !== 0) begin n_fail++; $display("FAIL mode3_pulses: valid %0d err %0d need 1 0", v3_cnt, e3_cnt); end
        $display("[TB] mode3: master read %h, rx_data %h", rd, rx_data3);
    endtask

    task automatic test_short();
        logic [31:0] rd;
        int lat;
        tx_data0 = 16'h0F0F;
        clear_mon();
        frame0(9, 16'hFFFF, rd);
        measure0(lat);
        n_tests++; if (e_cnt !== 1) begin n_fail++; $display("FAIL short_err_count: got %0d need 1", e_cnt); end
        n_tests++; if (v_cnt !== 0) begin n_fail++; $display("FAIL short_valid_count: got %0d need 0", v_cnt); end
        n_tests++; if (rx_data0 !== 16'h1234) begin n_fail++; $display("FAIL short_rx_kept: got %h need 1234", rx_data0); end
        n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL short_busy: got %b need 0", busy0); end
        $display("[TB] short 9-bit frame: errors %0d valids %0d rx %h", e_cnt, v_cnt, rx_data0);
    endtask

    task automatic test_long();
        logic [31:0] rd;
        int lat;
        tx_data0 = 16'hFFFF;
        clear_mon();
        frame0(17, 16'h5555, rd);
        measure0(lat);
        n_tests++; if (rd[31:16] !== 16'hFFFF) begin n_fail++; $display("FAIL long_miso: got %h need ffff", rd[31:16]); end
        n_tests++; if (rd[15] !== 1'b0) begin n_fail++; $display("FAIL long_bit17_idle: got %b need 0", rd[15]); end
        n_tests++; if (e_cnt !== 1 || v_cnt !== 0) begin n_fail++; $display("FAIL long_pulses: err %0d valid %0d need 1 0", e_cnt, v_cnt); end
        n_tests++; if (rx_data0 !== 16'h1234) begin n_fail++; $display("FAIL long_rx_kept: got %h need 1234", rx_data0); end
        $display("[TB] long 17-bit frame: bit17 %b errors %0d", rd[15], e_cnt);
    endtask

    task automatic test_empty();
        clear_mon();
        ss_n0 = 1'b0;
        repeat (10) @(negedge clk);
        ss_n0 = 1'b1;
        repeat (12) @(negedge clk);
        n_tests++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL empty_busy_seen: got %b need 1", busy_seen); end
        n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL empty_busy_end: got %b need 0", busy0); end
        n_tests++; if (v_cnt !== 0 || e_cnt !== 0) begin n_fail++; $display("FAIL empty_pulses: valid %0d err %0d need 0 0", v_cnt, e_cnt); end
        $display("[TB] empty frame: busy seen %b", busy_seen);
    endtask

    task automatic test_disabled();
        logic [31:0] rd;
        int lat;
        enable0 = 1'b0;
        tx_data0 = 16'hFFFF;
        clear_mon();
        frame0(16, 16'hBEEF, rd);
        measure0(lat);
        enable0 = 1'b1;
        n_tests++; if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL disabled_oe: got %b need 0", oe_seen); end
        n_tests++; if (v_cnt !== 0 || e_cnt !== 0) begin n_fail++; $display("FAIL disabled_pulses: valid %0d err %0d need 0 0", v_cnt, e_cnt); end
        n_tests++; if (rx_data0 !== 16'h1234) begin n_fail++; $display("FAIL disabled_rx_kept: got %h need 1234", rx_data0); end
        $display("[TB] disabled frame: oe seen %b rx %h", oe_seen, rx_data0);
    endtask

    task automatic test_reset_midframe();
        logic [15:0] mo;
        logic r;
        mo = 16'hC3C3;
        tx_data0 = 16'hFFFF;
        clear_mon();
        ss_n0 = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 8; i++) bit0(mo[15-i], r);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (busy0 !== 1'b0 || miso_oe0 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_oe: busy %b oe %b need 0 0", busy0, miso_oe0); end
        n_tests++; if (miso0 !== 1'b0) begin n_fail++; $display("FAIL midrst_miso: got %b need 0", miso0); end
        n_tests++; if (rx_data0 !== 16'h0000) begin n_fail++; $display("FAIL midrst_rx: got %h need 0000", rx_data0); end
        reset = 1'b0;
        clear_mon();
        for (int i = 8; i < 16; i++) bit0(mo[15-i], r);
        repeat (6) @(negedge clk);
        ss_n0 = 1'b1;
        repeat (12) @(negedge clk);
        n_tests++; if (v_cnt !== 0 || e_cnt !== 0) begin n_fail++; $display("FAIL midrst_pulses: valid %0d err %0d need 0 0", v_cnt, e_cnt); end
        n_tests++; if (busy_seen !== 1'b0 || oe_seen !== 1'b0) begin n_fail++; $display("FAIL midrst_restart: busy %b oe %b need 0 0", busy_seen, oe_seen); end
        $display("[TB] reset mid-frame: rx %h valids %0d errors %0d", rx_data0, v_cnt, e_cnt);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int lat;
        tx_data0 = 16'h8001;
        clear_mon();
        frame0(16, 16'hBEEF, rd);
        measure0(lat);
        n_tests++; if (rd[31:16] !== 16'h8001) begin n_fail++; $display("FAIL b2b_a_miso: got %h need 8001", rd[31:16]); end
        n_tests++; if (rx_data0 !== 16'hBEEF || v_cnt !== 1) begin n_fail++; $display("FAIL b2b_a_rx: got %h x%0d need beef x1", rx_data0, v_cnt); end
        $display("[TB] b2b frame a: master read %h, rx_data %h", rd[31:16], rx_data0);
        tx_data0 = 16'h7FFE;
        clear_mon();
        frame0(16, 16'h0F0F, rd);
        measure0(lat);
        n_tests++; if (rd[31:16] !== 16'h7FFE) begin n_fail++; $display("FAIL b2b_b_miso: got %h need 7ffe", rd[31:16]); end
        n_tests++; if (rx_data0 !== 16'h0F0F || v_cnt !== 1) begin n_fail++; $display("FAIL b2b_b_rx: got %h x%0d need 0f0f x1", rx_data0, v_cnt); end
        n_tests++; if (both_cnt !== 0) begin n_fail++; $display("FAIL pulses_overlap: got %0d need 0", both_cnt); end
        $display("[TB] b2b frame b: master read %h, rx_data %h", rd[31:16], rx_data0);
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_short();
        test_long();
        test_empty();
        test_disabled();
        test_reset_midframe();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
